// File: rtl/laplace_window_gen_if.sv
// Stream bundle for laplace_window_gen: raster pixels in, 5-point cross windows out.
// With LAPLACE_WIN_FRAME_CNT_EN defined the bundle also carries out_sof and frame_cnt.
interface laplace_window_gen_if #(
   parameter int PW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_pixel;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] b;
   logic [PW-1:0] d;
   logic [PW-1:0] e;
   logic [PW-1:0] f;
   logic [PW-1:0] h;
   logic          out_last;
`ifdef LAPLACE_WIN_FRAME_CNT_EN
   logic          out_sof;
   logic [15:0]   frame_cnt;

   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, b, d, e, f, h, out_last, out_sof, frame_cnt
   );
   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, b, d, e, f, h, out_last, out_sof, frame_cnt
   );
`else
   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, b, d, e, f, h, out_last
   );
   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, b, d, e, f, h, out_last
   );
`endif
endinterface

// File: rtl/laplace_window_gen.sv
// Two-line-buffer window generator emitting the (b,d,e,f,h) cross around every interior pixel.
// Optional LAPLACE_WIN_FRAME_CNT_EN adds out_sof and a 16-bit frame counter.
module laplace_window_gen #(
   parameter int COLS = 512,
   parameter int ROWS = 512,
   parameter int PW   = 8
) (
   input logic                clk,
   input logic                rst,
   laplace_window_gen_if.slave bus
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;

   logic [PW-1:0] lb1 [COLS];
   logic [PW-1:0] lb2 [COLS];
   logic [PW-1:0] lb1_rd;
   logic [PW-1:0] lb2_rd;

   logic [PW-1:0] t_cur_d1;
   logic [PW-1:0] t1_d1;
   logic [PW-1:0] t1_d2;
   logic [PW-1:0] t2_d1;

   logic          vld_p1;
   logic [PW-1:0] b_p1, d_p1, e_p1, f_p1, h_p1;
   logic          last_p1;

   logic accept;
   logic col_end;
   logic row_end;
   logic win_fire;

   assign bus.in_ready = !vld_p1 || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign col_end      = (col_cnt == CW'(COLS - 1));
   assign row_end      = (row_cnt == RW'(ROWS - 1));
   assign win_fire     = accept && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

   assign lb1_rd = lb1[col_cnt];
   assign lb2_rd = lb2[col_cnt];

   // Line buffers are read before the write on the same edge, so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb2[col_cnt] <= lb1_rd;
         lb1[col_cnt] <= bus.in_pixel;
      end
   end

   // Stage p0 -> p1: counters, taps and the registered output window
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt  <= '0;
         row_cnt  <= '0;
         t_cur_d1 <= '0;
         t1_d1    <= '0;
         t1_d2    <= '0;
         t2_d1    <= '0;
         vld_p1   <= 1'b0;
         last_p1  <= 1'b0;
         b_p1     <= '0;
         d_p1     <= '0;
         e_p1     <= '0;
         f_p1     <= '0;
         h_p1     <= '0;
      end else begin
         if (accept) begin
            t_cur_d1 <= bus.in_pixel;
            t1_d1    <= lb1_rd;
            t1_d2    <= t1_d1;
            t2_d1    <= lb2_rd;
            if (col_end) begin
               col_cnt <= '0;
               row_cnt <= row_end ? '0 : row_cnt + RW'(1);
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
         end
         if (win_fire) begin
            vld_p1  <= 1'b1;
            b_p1    <= t2_d1;
            d_p1    <= t1_d2;
            e_p1    <= t1_d1;
            f_p1    <= lb1_rd;
            h_p1    <= t_cur_d1;
            last_p1 <= row_end && col_end;
         end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.b         = b_p1;
   assign bus.d         = d_p1;
   assign bus.e         = e_p1;
   assign bus.f         = f_p1;
   assign bus.h         = h_p1;
   assign bus.out_last  = last_p1;

`ifdef LAPLACE_WIN_FRAME_CNT_EN
   logic        sof_p1;
   logic [15:0] frame_cnt;

   // The first window of a frame is formed by the accept at (2,2).
   always_ff @(posedge clk) begin
      if (rst) begin
         sof_p1    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (win_fire) begin
            sof_p1 <= (row_cnt == RW'(2)) && (col_cnt == CW'(2));
         end else if (bus.out_ready) begin
            sof_p1 <= 1'b0;
         end
         if (vld_p1 && bus.out_ready && last_p1) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign bus.out_sof   = sof_p1;
   assign bus.frame_cnt = frame_cnt;
`endif
endmodule

// File: tb/tb_laplace_window_gen.sv
// Directed bench for laplace_window_gen on a 4x4 frame with pixel = base | (row<<4) | col.
module tb_laplace_window_gen;
   localparam int COLS = 4;
   localparam int ROWS = 4;
   localparam int PW   = 8;

   typedef struct packed {
      logic [7:0]  b;
      logic [7:0]  d;
      logic [7:0]  e;
      logic [7:0]  f;
      logic [7:0]  h;
      logic        last;
      logic        sof;
      logic [15:0] fc;
   } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   acc_cyc = -1;

   win_t got[$];
   int   got_cyc[$];
   win_t exp_q[$];

   laplace_window_gen_if #(.PW(PW)) bus ();

   laplace_window_gen #(.COLS(COLS), .ROWS(ROWS), .PW(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         win_t w;
         w = '0;
         w.b = bus.b; w.d = bus.d; w.e = bus.e; w.f = bus.f; w.h = bus.h;
         w.last = bus.out_last;
`ifdef LAPLACE_WIN_FRAME_CNT_EN
         w.sof = bus.out_sof;
         w.fc  = bus.frame_cnt;
`endif
         got.push_back(w);
         got_cyc.push_back(cyc);
      end
   end

   // Appends the four expected windows of one 4x4 frame (centres (1,1),(1,2),(2,1),(2,2)).
   task automatic build_exp(input int base, input int fc);
      for (int r = 1; r <= 2; r++) begin
         for (int c = 1; c <= 2; c++) begin
            win_t w;
            w = '0;
            w.b = 8'(base | ((r - 1) << 4) | c);
            w.d = 8'(base | (r << 4) | (c - 1));
            w.e = 8'(base | (r << 4) | c);
            w.f = 8'(base | (r << 4) | (c + 1));
            w.h = 8'(base | ((r + 1) << 4) | c);
            w.last = (r == 2 && c == 2);
`ifdef LAPLACE_WIN_FRAME_CNT_EN
            w.sof = (r == 1 && c == 1);
            w.fc  = 16'(fc);
`endif
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   // Drives up to n_max pixels of a frame; leaves in_valid as-is for back-to-back frames.
   task automatic drive_frame(input int base, input int n_max, input bit gap);
      int n = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int  guard = 0;
            logic acc;
            if (n == n_max) return;
            if (gap) begin
               bus.in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(base | (r << 4) | c);
            forever begin
               @(negedge clk);
               acc = bus.in_ready;
               if (acc && base == 0 && r == 2 && c == 2) acc_cyc = cyc;
               @(posedge clk);
               #1;
               if (acc) break;
               guard++;
               if (guard > 200) begin
                  total_cnt++;
                  $display("FAIL accept_timeout pixel=%h in_ready stuck at 0, required 1", bus.in_pixel);
                  return;
               end
            end
            n++;
         end
      end
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got=%b want=0", bus.out_last);
      else pass_cnt++;
      total_cnt++;
      if ({bus.b, bus.d, bus.e, bus.f, bus.h} !== 40'h0)
         $display("FAIL reset_window got=%h want=0", {bus.b, bus.d, bus.e, bus.f, bus.h});
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_basic();
      apply_reset();
      drive_frame(0, 16, 1'b0);
      drain();
      build_exp(0, 0);
      total_cnt++;
      if (got.size() !== 4) $display("FAIL basic_count got=%0d want=4", got.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         total_cnt++;
         if (i >= got.size()) $display("FAIL basic_win%0d missing want=%h", i, exp_q[i]);
         else if (got[i] !== exp_q[i]) $display("FAIL basic_win%0d got=%h want=%h", i, got[i], exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (got_cyc.size() == 0 || got_cyc[0] !== acc_cyc + 1)
         $display("FAIL basic_latency got=%0d want=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0], acc_cyc + 1);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      win_t snap;
      apply_reset();
      fork
         drive_frame(0, 16, 1'b0);
         begin
            int guard = 0;
            bit seen = 0;
            while (guard < 200 && !seen) begin
               @(posedge clk);
               #1;
               seen = bus.out_valid;
               guard++;
            end
            if (!seen) begin
               total_cnt++;
               $display("FAIL bp_no_window out_valid stayed 0, required 1");
            end else begin
               bus.out_ready = 1'b0;
               snap = '0;
               snap.b = bus.b; snap.d = bus.d; snap.e = bus.e; snap.f = bus.f; snap.h = bus.h;
               snap.last = bus.out_last;
               for (int i = 0; i < 5; i++) begin
                  @(negedge clk);
                  total_cnt++;
                  if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                      {bus.b, bus.d, bus.e, bus.f, bus.h, bus.out_last} !==
                      {snap.b, snap.d, snap.e, snap.f, snap.h, snap.last})
                     $display("FAIL bp_stall%0d in_ready=%b out_valid=%b win=%h want in_ready=0 out_valid=1 win=%h",
                              i, bus.in_ready, bus.out_valid, {bus.b, bus.d, bus.e, bus.f, bus.h},
                              {snap.b, snap.d, snap.e, snap.f, snap.h});
                  else pass_cnt++;
               end
               @(posedge clk);
               #1 bus.out_ready = 1'b1;
            end
         end
      join
      drain();
      build_exp(0, 0);
      total_cnt++;
      if (got.size() !== 4) $display("FAIL bp_count got=%0d want=4", got.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         total_cnt++;
         if (i >= got.size()) $display("FAIL bp_win%0d missing want=%h", i, exp_q[i]);
         else if (got[i] !== exp_q[i]) $display("FAIL bp_win%0d got=%h want=%h", i, got[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drive_frame(0, 16, 1'b0);
      drive_frame(8'h80, 16, 1'b0);
      drain();
      build_exp(0, 0);
      build_exp(8'h80, 1);
      total_cnt++;
      if (got.size() !== 8) $display("FAIL b2b_count got=%0d want=8", got.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         total_cnt++;
         if (i >= got.size()) $display("FAIL b2b_win%0d missing want=%h", i, exp_q[i]);
         else if (got[i] !== exp_q[i]) $display("FAIL b2b_win%0d got=%h want=%h", i, got[i], exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (got.size() < 5 || got[4].b !== 8'h81 || got[4].e !== 8'h91)
         $display("FAIL b2b_second_first got_b=%h got_e=%h want b=81 e=91",
                  (got.size() < 5) ? 8'h00 : got[4].b, (got.size() < 5) ? 8'h00 : got[4].e);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive_frame(0, 9, 1'b0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b want=0", bus.out_valid);
      else pass_cnt++;
      got.delete();
      got_cyc.delete();
      @(posedge clk);
      #1;
      drive_frame(0, 16, 1'b0);
      drain();
      build_exp(0, 0);
      total_cnt++;
      if (got.size() !== 4) $display("FAIL rstmid_count got=%0d want=4", got.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         total_cnt++;
         if (i >= got.size()) $display("FAIL rstmid_win%0d missing want=%h", i, exp_q[i]);
         else if (got[i] !== exp_q[i]) $display("FAIL rstmid_win%0d got=%h want=%h", i, got[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_gapped();
      apply_reset();
      drive_frame(0, 16, 1'b1);
      drain();
      build_exp(0, 0);
      total_cnt++;
      if (got.size() !== 4) $display("FAIL gap_count got=%0d want=4", got.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         total_cnt++;
         if (i >= got.size()) $display("FAIL gap_win%0d missing want=%h", i, exp_q[i]);
         else if (got[i] !== exp_q[i]) $display("FAIL gap_win%0d got=%h want=%h", i, got[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_gapped();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
